// File: rtl/rriot_bus_initiator.sv
// Bus-cycle initiator for the 6530 RRIOT: queues host commands and replays them
// as phi2-timed read/write cycles, capturing read data and latching responder IRQs.
module rriot_bus_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic       cmd_rs0,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [9:0] rsp_addr,
    output logic [9:0] bus_a,
    output logic       bus_rs0,
    output logic       bus_r_w,
    output logic       bus_cs1,
    output logic [7:0] bus_do,
    output logic       bus_oe,
    input  logic [7:0] bus_di,
    input  logic       irq_n,
    output logic       irq_pending,
    input  logic       irq_clr,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic       we;
        logic       rs0;
        logic [9:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    cmd_t          fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop, capture;
    cmd_t          head;
    state_t        state, state_next;
    logic [2:0]    lat_cnt;
    logic          irq_sync1, irq_sync2, irq_prev, irq_fall;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    // WR shares IDLE's launch path so writes can issue back-to-back
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE, WR: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = head.we ? WR : RD;
                end else begin
                    state_next = IDLE;
                end
            end
            RD: begin
                if (lat_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge phi2) begin
        if (push) fifo_mem[wr_ptr] <= '{we: cmd_we, rs0: cmd_rs0, addr: cmd_addr, wdata: cmd_wdata};
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            bus_a     <= '0;
            bus_rs0   <= 1'b0;
            bus_r_w   <= 1'b1;
            bus_cs1   <= 1'b0;
            bus_do    <= '0;
            bus_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= capture;
            if (pop) begin
                bus_a   <= head.addr;
                bus_rs0 <= head.rs0;
                bus_cs1 <= 1'b1;
                bus_r_w <= !head.we;
                bus_oe  <= head.we;
                if (head.we) bus_do <= head.wdata;
                lat_cnt <= 3'(RD_LAT - 1);
            end else begin
                if (state_next == IDLE) begin
                    bus_cs1 <= 1'b0;
                    bus_r_w <= 1'b1;
                    bus_oe  <= 1'b0;
                end
                if (state == RD && lat_cnt != '0) lat_cnt <= lat_cnt - 3'd1;
            end
            if (capture) begin
                rsp_rdata <= bus_di;
                rsp_addr  <= bus_a;
            end
        end
    end

    assign irq_fall = irq_prev && !irq_sync2;

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync1   <= 1'b1;
            irq_sync2   <= 1'b1;
            irq_prev    <= 1'b1;
            irq_pending <= 1'b0;
        end else begin
            irq_sync1 <= irq_n;
            irq_sync2 <= irq_sync1;
            irq_prev  <= irq_sync2;
            if (irq_fall)     irq_pending <= 1'b1;
            else if (irq_clr) irq_pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rriot_bus_initiator.sv
// Self-checking bench for rriot_bus_initiator: directed scenarios plus random
// traffic, compared every cycle against a launch-schedule reference model.
module tb_rriot_bus_initiator;
    localparam int DEPTH = 4;
    localparam int RDL   = 2;
    localparam int MAXE  = 4096;
    localparam int MAXC  = 1024;

    logic       phi2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_we = 1'b0, cmd_rs0 = 1'b0;
    logic [9:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0, bus_di = '0;
    logic       irq_n = 1'b1, irq_clr = 1'b0;
    logic       cmd_ready, rsp_valid, bus_rs0, bus_r_w, bus_cs1, bus_oe, irq_pending, busy;
    logic [7:0] rsp_rdata, bus_do;
    logic [9:0] rsp_addr, bus_a;

    rriot_bus_initiator #(.FIFO_DEPTH(DEPTH), .RD_LAT(RDL)) dut (
        .phi2(phi2), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_rs0(cmd_rs0),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .bus_a(bus_a), .bus_rs0(bus_rs0), .bus_r_w(bus_r_w), .bus_cs1(bus_cs1),
        .bus_do(bus_do), .bus_oe(bus_oe), .bus_di(bus_di),
        .irq_n(irq_n), .irq_pending(irq_pending), .irq_clr(irq_clr), .busy(busy)
    );

    always #5 phi2 = ~phi2;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: each accepted command gets its launch edge from
    // max(push+1, end of previous cycle); everything else follows from that.
    int         base = 0, ncmd = 0, last_end = 0;
    int         c_p [MAXC];
    int         c_l [MAXC];
    bit         c_we [MAXC];
    bit         c_rs0 [MAXC];
    logic [9:0] c_a [MAXC];
    logic [7:0] c_d [MAXC];
    logic [7:0] di_hist [MAXE];
    bit         irq_h [MAXE];
    bit         pend = 1'b0;

    bit         e_cs1, e_rw, e_oe, e_rs0, e_rv, e_ready, e_busy, e_launched;
    logic [9:0] e_a, e_ra;
    logic [7:0] e_do, e_rd;
    int         e_occ;

    int rsp_seen = 0, nr_seen = 0, cs1_seen = 0;

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task expect_at(input int e);
        bit active;
        active = 1'b0;
        e_cs1 = 1'b0; e_rw = 1'b1; e_oe = 1'b0; e_rs0 = 1'b0; e_rv = 1'b0;
        e_a = '0; e_ra = '0; e_do = '0; e_rd = '0; e_occ = 0; e_launched = 1'b0;
        for (int i = base; i < ncmd; i++) begin
            if (c_p[i] <= e) e_occ++;
            if (c_l[i] <= e) begin
                e_occ--;
                e_launched = 1'b1;
                e_a = c_a[i];
                e_rs0 = c_rs0[i];
                if (c_we[i]) e_do = c_d[i];
            end
            if (c_we[i] && c_l[i] == e) begin
                e_cs1 = 1'b1; e_rw = 1'b0; e_oe = 1'b1; active = 1'b1;
            end
            if (!c_we[i] && c_l[i] <= e && e < c_l[i] + RDL) begin
                e_cs1 = 1'b1; active = 1'b1;
            end
            if (!c_we[i] && c_l[i] + RDL <= e) begin
                e_rd = di_hist[c_l[i] + RDL];
                e_ra = c_a[i];
                e_rv = (c_l[i] + RDL == e);
            end
        end
        e_ready = (e_occ < DEPTH);
        e_busy  = (e_occ > 0) || active;
    endtask

    task check_all();
        expect_at(edge_n);
        chk("cmd_ready",   32'(cmd_ready),   32'(e_ready));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("bus_cs1",     32'(bus_cs1),     32'(e_cs1));
        chk("bus_r_w",     32'(bus_r_w),     32'(e_rw));
        chk("bus_oe",      32'(bus_oe),      32'(e_oe));
        chk("bus_a",       32'(bus_a),       32'(e_a));
        chk("bus_rs0",     32'(bus_rs0),     32'(e_rs0));
        chk("rsp_valid",   32'(rsp_valid),   32'(e_rv));
        chk("rsp_rdata",   32'(rsp_rdata),   32'(e_rd));
        chk("rsp_addr",    32'(rsp_addr),    32'(e_ra));
        chk("irq_pending", 32'(irq_pending), 32'(pend));
        if (e_oe || !e_launched) chk("bus_do", 32'(bus_do), 32'(e_do));
        if (rsp_valid)  rsp_seen++;
        if (!cmd_ready) nr_seen++;
        if (bus_cs1)    cs1_seen++;
    endtask

    task model_reset();
        base = ncmd;
        last_end = 0;
        pend = 1'b0;
        for (int k = 0; k < 3; k++)
            if (edge_n - k >= 0) irq_h[edge_n - k] = 1'b1;
    endtask

    task tick();
        bit push;
        expect_at(edge_n);
        push = rst_n && cmd_valid && e_ready;
        @(posedge phi2);
        edge_n++;
        di_hist[edge_n] = bus_di;
        irq_h[edge_n] = rst_n ? irq_n : 1'b1;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (push) begin
                c_p[ncmd]   = edge_n;
                c_l[ncmd]   = (edge_n + 1 > last_end) ? edge_n + 1 : last_end;
                c_we[ncmd]  = cmd_we;
                c_rs0[ncmd] = cmd_rs0;
                c_a[ncmd]   = cmd_addr;
                c_d[ncmd]   = cmd_wdata;
                last_end    = c_l[ncmd] + (cmd_we ? 1 : RDL + 1);
                ncmd++;
            end
            if (edge_n >= 3 && !irq_h[edge_n - 2] && irq_h[edge_n - 3]) pend = 1'b1;
            else if (irq_clr) pend = 1'b0;
        end
        #1;
        check_all();
        bus_di = 8'($urandom);
    endtask

    task assert_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    task push_cmd(input bit we, input bit rs0, input logic [9:0] a, input logic [7:0] d);
        bit acc;
        int n;
        cmd_valid = 1'b1; cmd_we = we; cmd_rs0 = rs0; cmd_addr = a; cmd_wdata = d;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 32) begin
            expect_at(edge_n);
            acc = e_ready;
            tick();
            n++;
        end
        chk("push_bound", 32'(acc), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        for (int i = 0; i < MAXE; i++) begin
            irq_h[i] = 1'b1;
            di_hist[i] = '0;
        end

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single write
        push_cmd(1'b1, 1'b1, 10'h3FF, 8'hA5);
        cmd_valid = 1'b0;
        tick();
        chk("wr_cs1", 32'(bus_cs1), 32'(1));
        chk("wr_r_w", 32'(bus_r_w), 32'(0));
        chk("wr_oe",  32'(bus_oe),  32'(1));
        chk("wr_a",   32'(bus_a),   32'h3FF);
        chk("wr_do",  32'(bus_do),  32'hA5);
        tick();
        chk("wr_end_cs1", 32'(bus_cs1), 32'(0));
        chk("wr_end_oe",  32'(bus_oe),  32'(0));

        // Single read, data presented at the sample edge
        push_cmd(1'b0, 1'b0, 10'h080, 8'h00);
        cmd_valid = 1'b0;
        tick();
        tick();
        bus_di = 8'h5A;
        tick();
        chk("rd_valid",    32'(rsp_valid), 32'(1));
        chk("rd_rdata",    32'(rsp_rdata), 32'h5A);
        chk("rd_addr",     32'(rsp_addr),  32'h080);
        chk("rd_turn_cs1", 32'(bus_cs1),   32'(0));
        tick();
        chk("rd_pulse_end", 32'(rsp_valid), 32'(0));

        // Fill the FIFO behind stalled reads
        nr_seen = 0;
        push_cmd(1'b0, 1'b1, 10'h010, 8'h00);
        push_cmd(1'b0, 1'b0, 10'h011, 8'h00);
        push_cmd(1'b1, 1'b0, 10'h100, 8'h11);
        push_cmd(1'b1, 1'b1, 10'h101, 8'h22);
        push_cmd(1'b1, 1'b0, 10'h102, 8'h33);
        push_cmd(1'b1, 1'b1, 10'h103, 8'h44);
        push_cmd(1'b1, 1'b0, 10'h104, 8'h55);
        cmd_valid = 1'b0;
        chk("fifo_full_seen", 32'(nr_seen > 0), 32'(1));
        repeat (15) tick();

        // Alternating read/write stream
        rsp_seen = 0;
        for (int i = 0; i < 6; i++)
            push_cmd(i % 2 == 1, 1'(i), 10'($urandom), 8'($urandom));
        cmd_valid = 1'b0;
        repeat (15) tick();
        chk("alt_rsp_count", 32'(rsp_seen), 32'(3));

        // Reset one cycle after a read launch, with a write still queued
        push_cmd(1'b0, 1'b0, 10'h2AA, 8'h00);
        idx = ncmd - 1;
        push_cmd(1'b1, 1'b1, 10'h155, 8'h77);
        cmd_valid = 1'b0;
        while (edge_n < c_l[idx] + 1) tick();
        rsp_seen = 0;
        cs1_seen = 0;
        assert_reset();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("rst_no_rsp", 32'(rsp_seen), 32'(0));
        chk("rst_no_cs1", 32'(cs1_seen), 32'(0));

        // IRQ latency, clear, and set-beats-clear
        irq_n = 1'b0;
        tick();
        tick();
        chk("irq_2edges", 32'(irq_pending), 32'(0));
        tick();
        chk("irq_3edges", 32'(irq_pending), 32'(1));
        irq_n = 1'b1;
        repeat (3) tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_clr", 32'(irq_pending), 32'(0));
        irq_n = 1'b0;
        tick();
        tick();
        irq_clr = 1'b1;
        tick();
        chk("irq_set_wins", 32'(irq_pending), 32'(1));
        tick();
        chk("irq_clr_alone", 32'(irq_pending), 32'(0));
        irq_clr = 1'b0;
        irq_n = 1'b1;
        repeat (3) tick();

        // Random traffic with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_rs0   = 1'($urandom_range(0, 1));
            cmd_addr  = 10'($urandom);
            cmd_wdata = 8'($urandom);
            if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
            irq_clr = ($urandom_range(0, 7) == 0);
            if (i == 200) begin
                assert_reset();
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        irq_clr = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rriot_bus_initiator.md
# rriot_bus_initiator

Bus-cycle initiator for the 6530 RRIOT bus: the master end of the address/data/R_W/CS1/RS0 interface the RRIOT core responds to. Queues host commands (read or write, register/RAM select, 10-bit address, write data) in a small FIFO and replays them as phi2-timed bus cycles. Captures read data after a fixed responder latency, and reports IRQ assertions from the responder. Used as the on-FPGA bus driver for board bring-up and as the bench-side stimulus for the RRIOT core.

## Interface
Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
- RD_LAT, 2, phi2 edges from bus-cycle launch to read-data sample; legal range 1..4

Ports:
- phi2  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full; transfer on cmd_valid & cmd_ready at a rising edge
- cmd_we  in  1  1 = write, 0 = read
- cmd_rs0  in  1  RS0 value for the cycle
- cmd_addr  in  10  address
- cmd_wdata  in  8  write data, ignored for reads
- rsp_valid  out  1  one-cycle pulse, read data captured
- rsp_rdata  out  8  captured read data, held until next capture
- rsp_addr  out  10  address of the captured read
- bus_a  out  10  address to responder
- bus_rs0  out  1  RS0 to responder
- bus_r_w  out  1  1 = read, 0 = write
- bus_cs1  out  1  chip select, high during an active cycle
- bus_do  out  8  write data to responder
- bus_oe  out  1  data-bus drive enable
- bus_di  in  8  read data from responder
- irq_n  in  1  responder IRQ, active-low, asynchronous
- irq_pending  out  1  sticky IRQ flag
- irq_clr  in  1  clears irq_pending
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- FIFO: push on cmd_valid & cmd_ready. cmd_ready = !full, combinational. Push while full does not occur. Push and pop in the same edge are both allowed; occupancy is unchanged.
- FSM states: IDLE, WR, RD. All bus outputs are registered.
- IDLE: bus_cs1=0, bus_r_w=1, bus_oe=0. bus_a, bus_rs0 and bus_do hold their last values. If the FIFO is non-empty, pop the head, load the bus registers, and go to WR or RD per cmd_we.
- WR (one cycle): bus_cs1=1, bus_r_w=0, bus_oe=1, bus_do=wdata. On the next edge, if the FIFO is non-empty, pop and launch the next command directly (back-to-back); otherwise go to IDLE.
- RD: bus_cs1=1, bus_r_w=1, bus_oe=0. A down-counter is loaded with RD_LAT-1 at launch. At the edge where the counter is 0:
  - bus_di goes to rsp_rdata and the cycle address goes to rsp_addr.
  - rsp_valid pulses for one cycle.
  - The FSM goes to IDLE, giving one forced turnaround cycle with cs1=0.
- IRQ:
  - irq_n passes through a 2-flop synchronizer; both flops reset to 1.
  - A registered falling edge of the synchronized value sets irq_pending.
  - irq_clr clears irq_pending. If set and clear occur in the same cycle, set wins.
- rst_n low, including mid-cycle:
  - FIFO emptied; FSM to IDLE; in-flight read discarded (no rsp_valid).
  - Outputs reset to: bus_a=0, bus_rs0=0, bus_r_w=1, bus_cs1=0, bus_do=0, bus_oe=0, rsp_valid=0, rsp_rdata=0, rsp_addr=0, irq_pending=0.
  - Resulting combinational values: cmd_ready=1, busy=0.

## Timing
- Command accepted at edge k into an empty FIFO with the FSM in IDLE → bus cycle launched at edge k+1.
- Write throughput: 1 per phi2 cycle while the FIFO stays non-empty.
- Read launched at edge t: bus_di sampled at edge t+RD_LAT; rsp_valid high from t+RD_LAT to t+RD_LAT+1; next launch no earlier than t+RD_LAT+1.
- Write launched at edge t, followed by any command: next launch at t+1.
- irq_n fall → irq_pending high 3 edges later (2 sync + 1 edge detect).

## Test plan
- Single write (addr=0x3FF, rs0=1, wdata=0xA5) after reset → one cycle later cs1=1, r_w=0, oe=1, bus_a=0x3FF, bus_do=0xA5 for exactly 1 cycle; then IDLE values.
- Single read at addr=0x080 with RD_LAT=2, bus_di=0x5A at the sample edge → rsp_valid pulse 2 edges after launch with rsp_rdata=0x5A, rsp_addr=0x080; cs1 low for 1 turnaround cycle.
- Push 4 writes back-to-back with FIFO_DEPTH=4 and the FSM stalled in a read → cmd_ready drops after the 4th push; all 4 writes appear on consecutive cycles in push order.
- Alternating read/write stream of 6 commands → read-to-next spacing RD_LAT+1 and write-to-next spacing 1; rsp_valid pulses exactly 3 times with the correct data.
- Assert rst_n low one cycle after a read launch → no rsp_valid; all outputs at their reset values; a queued FIFO entry is never issued.
- Pulse irq_n low → irq_pending=1 after 3 edges; irq_clr asserted on the same cycle as a new set → irq_pending stays 1; irq_clr alone → 0.
